subtractor_serial_amisha: RTL
=============================

Name: subtractor_serial_amisha

Overview:
Parameterised bit-serial unsigned/two's-complement subtractor computing a − b, one bit per clock, LSB first, with a start/done handshake. It is the inverse-operation counterpart to the team's parallel carry adder and targets area-constrained paths. A single wrapper can instantiate it at several widths through the N parameter.

Parameters:
N, 4, operand and result width in bits; legal range 2..32.

Ports:
clk_amisha  input  1  system clock, all state updates on rising edge
rst_n_amisha  input  1  asynchronous active-low reset
start_amisha  input  1  request pulse/level; sampled only in IDLE
a_amisha  input  N  minuend; sampled on the accepting edge only
b_amisha  input  N  subtrahend; sampled on the accepting edge only
busy_amisha  output  1  high while an operation is in progress (RUN or DONE)
done_amisha  output  1  single-cycle pulse; results are valid and updated
diff_amisha  output  N  result a − b mod 2^N; holds until the next done
bout_amisha  output  1  borrow out; 1 iff unsigned a < b
ovf_amisha  output  1  signed overflow flag for two's-complement a − b

Behaviour:
- Clock is clk_amisha. Reset rst_n_amisha is asynchronous and active-low.
- Reset (asynchronous, while low): state=IDLE, counter=0, internal borrow=0, operand/shift registers=0. Outputs: busy=0, done=0, diff=0, bout=0, ovf=0.
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1 at a rising edge, latch a into the A shift register and b into the B shift register. Clear the borrow, set cnt=0 and go to RUN. Otherwise stay in IDLE.
- RUN: on each edge:
  - d = A[0] ^ B[0] ^ borrow.
  - borrow_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & borrow).
  - Shift A and B right, and shift d into the MSB of the result shift register.
  - cnt increments.
  - On the edge that processes bit N−1 (cnt==N−1): go to DONE, load diff with the full result, set bout=borrow_next, set ovf=(a[N-1]!=b[N-1]) & (diff[N-1]!=a[N-1]) using the latched operand MSBs, and assert done=1.
- DONE: lasts one cycle. On the next edge done returns to 0 and the state goes to IDLE.
- Latency: the start edge is E0. done is high in the cycle following edge EN, i.e. N clocks after acceptance. busy is high from after E0 until after EN+1. Throughput is one result per N+2 clocks.
- start while busy (RUN or DONE) is ignored; it is neither queued nor able to corrupt the operands. A start held high continuously restarts from IDLE on the edge after DONE.
- Operand inputs may change freely after E0 without effect.
- diff, bout and ovf update only in the done cycle and otherwise hold their last values.
- Reset asserted mid-RUN aborts the operation: no done pulse, and all outputs return to reset values. After reset deasserts, the block is ready in IDLE.
- The counter width is clog2(N). The counter must not wrap through an illegal value for non-power-of-two N.

Test Plan:
- N=4, a=9, b=3, start for one cycle -> done exactly 4 clocks after acceptance. diff=6, bout=0, ovf=1. busy spans 5 cycles.
- N=4, a=3, b=9 -> diff=10 (4'b1010), bout=1, ovf=1. Then a=5, b=5 -> diff=0, bout=0, ovf=0.
- N=8, a=8'h00, b=8'h01 -> diff=8'hFF, bout=1, ovf=0. Then a=8'h80, b=8'h01 -> diff=8'h7F, bout=0, ovf=1, with done after 8 clocks.
- N=4, start a=9, b=3; on the 2nd RUN cycle pulse start with a=1, b=1 -> single done with diff=6. No second done occurs without a new start in IDLE.
- N=8, reset asserted during RUN cycle 3 -> busy, done, diff, bout and ovf go to 0 immediately (asynchronously) and no done follows. A new start a=8'h10, b=8'h01 then yields diff=8'h0F.
- Start held high across 3 operations with N=4 -> done pulses are spaced exactly N+2=6 clocks apart, and diff/bout/ovf are stable between pulses.

Source files
------------

// File: rtl/subtractor_serial_amisha_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller drives start and operands; the subtractor returns status and results.
interface subtractor_serial_amisha_if #(
  parameter int N = 4
);
  logic         start_amisha;
  logic [N-1:0] a_amisha;
  logic [N-1:0] b_amisha;
  logic         busy_amisha;
  logic         done_amisha;
  logic [N-1:0] diff_amisha;
  logic         bout_amisha;
  logic         ovf_amisha;

  modport master (
    output start_amisha, a_amisha, b_amisha,
    input  busy_amisha, done_amisha, diff_amisha, bout_amisha, ovf_amisha
  );

  modport slave (
    input  start_amisha, a_amisha, b_amisha,
    output busy_amisha, done_amisha, diff_amisha, bout_amisha, ovf_amisha
  );
endinterface

// File: rtl/subtractor_serial_amisha.sv
// Bit-serial a - b subtractor, one bit per clock LSB first, with start/done handshake.
// Results, borrow-out and signed overflow are registered and held between done pulses.
module subtractor_serial_amisha #(
  parameter int N = 4
) (
  input  logic                         clk_amisha,
  input  logic                         rst_n_amisha,
  subtractor_serial_amisha_if.slave    bus_amisha
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic [N-1:0]  aShift_q, aShift_d;
  logic [N-1:0]  bShift_q, bShift_d;
  logic [N-2:0]  resShift_q, resShift_d;
  logic          aMsb_q, aMsb_d;
  logic          bMsb_q, bMsb_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic          dBit;
  logic          borrowNext;
  logic [N-1:0]  resFull;

  assign dBit       = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
  assign borrowNext = (~aShift_q[0] & bShift_q[0]) | (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
  // The newest bit lands on top; after N-1 shifts the oldest bit sits at position 0.
  assign resFull    = {dBit, resShift_q};

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      aShift_q   <= '0;
      bShift_q   <= '0;
      resShift_q <= '0;
      aMsb_q     <= 1'b0;
      bMsb_q     <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      resShift_q <= resShift_d;
      aMsb_q     <= aMsb_d;
      bMsb_q     <= bMsb_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    resShift_d = resShift_q;
    aMsb_d     = aMsb_q;
    bMsb_d     = bMsb_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_amisha.start_amisha) begin
          aShift_d = bus_amisha.a_amisha;
          bShift_d = bus_amisha.b_amisha;
          aMsb_d   = bus_amisha.a_amisha[N-1];
          bMsb_d   = bus_amisha.b_amisha[N-1];
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        aShift_d   = {1'b0, aShift_q[N-1:1]};
        bShift_d   = {1'b0, bShift_q[N-1:1]};
        resShift_d = resFull[N-1:1];
        borrow_d   = borrowNext;
        // Counter parks at zero on the last bit so it never passes an out-of-range value.
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          diff_d  = resFull;
          bout_d  = borrowNext;
          ovf_d   = (aMsb_q ^ bMsb_q) & (dBit ^ aMsb_q);
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus_amisha.busy_amisha = (state_q != IDLE);
  assign bus_amisha.done_amisha = done_q;
  assign bus_amisha.diff_amisha = diff_q;
  assign bus_amisha.bout_amisha = bout_q;
  assign bus_amisha.ovf_amisha  = ovf_q;

endmodule
